// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: FSM states, line-state encodings and CRC16 constants.
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        CRC,
        EOP_SE0A,
        EOP_SE0B,
        EOP_J
    } tx_state_t;

    // Line states as {dplus, dminus}
    typedef logic [1:0] line_t;

    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_SE0 = 2'b00;

    localparam logic [7:0] SYNC_BYTE  = 8'h80;
    localparam int         ONES_LIMIT = 6;

    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

    // A 0 bit toggles J/K, a 1 bit holds the current level
    function automatic line_t nrzi_next(input line_t cur, input logic b);
        if (b) begin
            return cur;
        end
        return (cur == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_crc16.sv
// CRC16 generator for the USB data payload; reflected register, LSB-first, one byte per load strobe.
module usb_tx_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        init,
    input  logic        load,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? POLY_REFL : 16'h0000);
    endfunction

    always_comb begin
        crc_next = crc_reg;
        if (init) begin
            crc_next = CRC16_INIT;
        end else if (load) begin
            for (int i = 0; i < 8; i++) begin
                crc_next = crc_step(crc_next, data[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_reg <= '0;
        end else begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC, NRZI, bit stuffing and EOP generation.
// Define USB_TX_CRC16_EN to append a stuffed CRC16 after the final data byte.
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_err,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef USB_TX_CRC16_EN
    localparam int SHIFT_W = 16;
`else
    localparam int SHIFT_W = 8;
`endif

    tx_state_t          state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SHIFT_W-1:0] shift_reg, shift_next;
    logic [3:0]         idx_reg, idx_next;
    logic [2:0]         ones_reg, ones_next;
    logic               last_reg, last_next;
    line_t              line_reg, line_next;

    logic       bit_end;
    logic       load_byte;
    logic       underrun;
    logic       start_pkt;
    logic       send_bit;
    logic       nxt_bit;
    logic [3:0] field_end;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_val;

    usb_tx_crc16 u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .init  (start_pkt),
        .load  (load_byte),
        .data  (tx_data),
        .crc   (crc_val)
    );
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            idx_reg   <= '0;
            ones_reg  <= '0;
            last_reg  <= 1'b0;
            line_reg  <= LINE_J;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            ones_reg  <= ones_next;
            last_reg  <= last_next;
            line_reg  <= line_next;
        end
    end

    // idx_reg names the last payload bit already on the line, so a stuff bit
    // leaves it untouched and the following bit resumes from the same place.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        ones_next  = ones_reg;
        last_next  = last_reg;
        line_next  = line_reg;
        load_byte  = 1'b0;
        underrun   = 1'b0;
        start_pkt  = 1'b0;
        send_bit   = 1'b0;
        nxt_bit    = 1'b0;
        bit_end    = (cnt_reg == CNT_LAST);
        field_end  = (state_reg == CRC) ? 4'd15 : 4'd7;

        if (state_reg != IDLE) begin
            cnt_next = bit_end ? '0 : cnt_reg + CNT_ONE;
        end

        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    state_next = SYNC;
                    cnt_next   = '0;
                    shift_next = SHIFT_W'(SYNC_BYTE);
                    idx_next   = '0;
                    ones_next  = '0;
                    last_next  = 1'b0;
                    start_pkt  = 1'b1;
                    send_bit   = 1'b1;
                    nxt_bit    = SYNC_BYTE[0];
                end
            end
            SYNC, DATA, CRC: begin
                if (bit_end) begin
                    if (ones_reg == 3'(ONES_LIMIT)) begin
                        send_bit = 1'b1;
                        nxt_bit  = 1'b0;
                    end else if (idx_reg != field_end) begin
                        shift_next = shift_reg >> 1;
                        idx_next   = idx_reg + 4'd1;
                        send_bit   = 1'b1;
                        nxt_bit    = shift_reg[1];
                    end else if (state_reg == DATA && last_reg) begin
`ifdef USB_TX_CRC16_EN
                        state_next = CRC;
                        shift_next = ~crc_val;
                        idx_next   = '0;
                        send_bit   = 1'b1;
                        nxt_bit    = ~crc_val[0];
`else
                        state_next = EOP_SE0A;
                        line_next  = LINE_SE0;
                        ones_next  = '0;
`endif
                    end else if (state_reg == CRC) begin
                        state_next = EOP_SE0A;
                        line_next  = LINE_SE0;
                        ones_next  = '0;
                    end else if (tx_valid) begin
                        load_byte  = 1'b1;
                        state_next = DATA;
                        shift_next = SHIFT_W'(tx_data);
                        idx_next   = '0;
                        last_next  = tx_last;
                        send_bit   = 1'b1;
                        nxt_bit    = tx_data[0];
                    end else begin
                        underrun   = 1'b1;
                        state_next = EOP_SE0A;
                        line_next  = LINE_SE0;
                        ones_next  = '0;
                    end
                end
            end
            EOP_SE0A: begin
                if (bit_end) begin
                    state_next = EOP_SE0B;
                end
            end
            EOP_SE0B: begin
                if (bit_end) begin
                    state_next = EOP_J;
                    line_next  = LINE_J;
                end
            end
            EOP_J: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (send_bit) begin
            line_next = nrzi_next(line_reg, nxt_bit);
            ones_next = nxt_bit ? ones_reg + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        tx_busy    = (state_reg != IDLE);
        tx_ready   = load_byte;
        tx_err     = underrun;
        dplus_out  = line_reg[1];
        dminus_out = line_reg[0];
    end

endmodule

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clk cycles per full-speed bit time (legal range 2 or more).
REQ-002 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tx_data, input, 8, packet byte, sent LSB first.
REQ-005 SHALL have port tx_valid, input, 1, tx_data valid; source holds it until tx_ready.
REQ-006 SHALL have port tx_last, input, 1, qualifies tx_data as the final byte of the packet.
REQ-007 SHALL have port tx_ready, output, 1, one-cycle pulse when the byte is loaded into the shifter.
REQ-008 SHALL have port tx_busy, output, 1, high from packet start until EOP J bit completes.
REQ-009 SHALL have port tx_err, output, 1, one-cycle pulse on underrun abort.
REQ-010 SHALL have port dplus_out, output, 1, encoded D+ line.
REQ-011 SHALL have port dminus_out, output, 1, encoded D- line.

Function
REQ-012 SHALL use line states J = (1,0), K = (0,1), SE0 = (0,0) on (dplus_out, dminus_out); idle is J.
REQ-013 SHALL implement states IDLE, SYNC, DATA, CRC, EOP_SE0A, EOP_SE0B, EOP_J.
REQ-014 SHALL leave IDLE when tx_valid is high, clear the bit-time counter, and drive the first SYNC bit starting the next cycle.
REQ-015 SHALL hold each line bit for exactly CLKS_PER_BIT cycles; outputs change only at bit-time boundaries.
REQ-016 SHALL send sync byte 8'h80 LSB first, producing KJKJKJKK from idle J.
REQ-017 SHALL NRZI-encode: a 0 bit toggles J/K, a 1 bit holds the current state.
REQ-018 SHALL load a byte and pulse tx_ready in the cycle the final bit time of the sync byte or previous data byte ends, if tx_valid is high.
REQ-019 SHALL treat tx_valid low at a byte boundary, with the previous byte not tx_last, as underrun: go to EOP_SE0A, pulse tx_err, and load no byte.
REQ-020 SHALL count consecutive 1s across sync, data and CRC, and insert a 0 (toggle) after the sixth 1.
REQ-021 SHALL reset the ones count on every transmitted 0, including stuff bits.
REQ-022 SHALL insert a pending stuff bit after the final data or CRC bit, before EOP.
REQ-023 SHALL not advance the shifter or the byte-boundary logic during a stuff bit.
REQ-024 SHALL send EOP as SE0, SE0, J (one bit time each), then enter IDLE with tx_busy low.
REQ-025 SHALL ignore tx_valid while tx_busy is high except at byte boundaries.

Reset
REQ-026 SHALL, on n_rst low (asynchronous), force state IDLE, dplus_out=1, dminus_out=0, and tx_ready=tx_busy=tx_err=0.
REQ-027 SHALL clear the counters, shifter, ones count and CRC register on reset.
REQ-028 SHALL emit no EOP when reset is asserted mid-packet.

Configuration
REQ-029 SHALL, with USB_TX_CRC16_EN defined, append CRC16 over the data bytes after the tx_last byte: poly 0x8005 reflected, init 16'hFFFF, complemented, LSB first, stuffed, in state CRC.
REQ-030 SHALL, without USB_TX_CRC16_EN, go directly from the tx_last byte to EOP; the CRC state and register SHALL be absent.

Structure
REQ-031 SHALL place the state enum, SYNC_BYTE, J/K/SE0 constants, CRC16_POLY, CRC16_INIT and CRC16_RESIDUE (16'h800D) in shared package usb_pkg.
REQ-032 SHALL implement CRC16 as sub-module usb_tx_crc16, instantiated only under USB_TX_CRC16_EN.

Verification
REQ-033 Reset: n_rst low -> dplus=1, dminus=0, tx_busy=0, tx_ready=0.
REQ-034 Byte 8'h00 with tx_last, CRC off -> KJKJKJKK, then JKJKJKJK, SE0, SE0, J; one tx_ready pulse; 19 bit times busy.
REQ-035 Byte 8'hFF with tx_last, CRC off -> sync, then K x5, stuff J, J x3, SE0, SE0, J (20 bit times).
REQ-036 Underrun: 8'hA5 without tx_last, tx_valid low at boundary -> after the A5 bits, SE0, SE0, J; tx_err pulse of exactly 1 cycle.
REQ-037 CRC on: data 8'h00, 8'h01, 8'h02, 8'h03 -> 16 appended bits; receiver-model CRC16 over data+CRC yields 16'h800D.
REQ-038 Reset mid-DATA -> J immediately, tx_busy=0; the next packet's sync is correct.
